// File: rtl/bipolar_mac_frame.sv
// ---------------------------------------------------------------------------
// bipolar_mac_frame
//
// Streaming signed multiply-accumulate engine for the correlation /
// pitch-estimation datapath. Each accepted (data, template) pair is
// multiplied on a sign-magnitude datapath. LEN products are summed per frame.
// The frame sum is then presented with a single-cycle valid pulse.
//
// Pipeline:
//   stage 1 : magnitude multiply, exact negate, sign-extend to AW (p1_q)
//   stage 2 : accumulate / load, overflow detect, clamp or wrap (acc_q)
//   output  : out_sum / out_ovf registered with the out_valid pulse
//
// Handshake: a sample pair is accepted on every rising edge where
// in_valid=1 and clear=0. There is no backpressure, so the producer never
// waits. out_valid is a one-cycle pulse. out_sum and out_ovf hold their
// values until the next pulse.
//
// Ports:
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   clear      in   1    synchronous frame abort / flush
//   in_valid   in   1    sample pair valid this cycle
//   in_data    in   DW   signed sample
//   in_tmpl    in   DW   signed template value
//   out_valid  out  1    one-cycle pulse, out_sum/out_ovf valid
//   out_sum    out  AW   signed frame sum
//   out_ovf    out  1    at least one signed overflow occurred in the frame
//   busy       out  1    frame in progress or a pipeline stage is valid
// ---------------------------------------------------------------------------
module bipolar_mac_frame #(
    parameter int DW  = 12,
    parameter int AW  = 36,
    parameter int LEN = 1024,
    parameter int SAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] in_tmpl,
    output logic          out_valid,
    output logic [AW-1:0] out_sum,
    output logic          out_ovf,
    output logic          busy
);

    localparam int PW = 2 * DW;
    localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DW-1:0] ONE_DW   = DW'(1);
    localparam logic [PW-1:0] ONE_PW   = PW'(1);
    localparam logic [AW-1:0] SUM_MAX  = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] SUM_MIN  = {1'b1, {(AW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Frame counter and sample acceptance
    // ------------------------------------------------------------------
    logic          accept;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          is_first, is_last;

    assign accept   = in_valid && !clear;
    assign is_first = (cnt_q == '0);
    assign is_last  = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (in_valid) begin
            cnt_d = is_last ? '0 : (cnt_q + CNT_ONE);
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: sign-magnitude multiply
    // ------------------------------------------------------------------
    logic          sign_d, sign_t, neg;
    logic [DW-1:0] mag_d, mag_t;
    logic [PW-1:0] prod_mag, prod_signed;
    logic [AW-1:0] prod_ext;

    assign sign_d = in_data[DW-1];
    assign sign_t = in_tmpl[DW-1];
    assign neg    = sign_d ^ sign_t;

    // The magnitude of the most negative value is 2^(DW-1). That value still
    // fits because mag_* is treated as unsigned.
    assign mag_d = sign_d ? (~in_data + ONE_DW) : in_data;
    assign mag_t = sign_t ? (~in_tmpl + ONE_DW) : in_tmpl;

    assign prod_mag = PW'(mag_d) * PW'(mag_t);

    // The largest magnitude product is 2^(2DW-2). The negated product
    // therefore always fits in PW signed bits.
    assign prod_signed = neg ? (~prod_mag + ONE_PW) : prod_mag;
    assign prod_ext    = AW'($signed(prod_signed));

    logic          v1_q;
    logic          first1_q;
    logic          last1_q;
    logic [AW-1:0] p1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            p1_q     <= '0;
        end else begin
            cnt_q <= cnt_d;
            v1_q  <= accept;
            if (clear) begin
                first1_q <= 1'b0;
                last1_q  <= 1'b0;
            end else if (in_valid) begin
                first1_q <= is_first;
                last1_q  <= is_last;
                p1_q     <= prod_ext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: accumulate with overflow detection
    // ------------------------------------------------------------------
    logic [AW-1:0] acc_q, acc_d;
    logic          sticky_q, sticky_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_sum_q, out_sum_d;
    logic          out_ovf_q, out_ovf_d;

    logic [AW:0]   sum_ext;
    logic [AW-1:0] acc_next;
    logic          ovf_now;

    assign sum_ext = {acc_q[AW-1], acc_q} + {p1_q[AW-1], p1_q};

    always_comb begin
        acc_next = sum_ext[AW-1:0];
        ovf_now  = 1'b0;
        if (first1_q) begin
            // The first product of a frame loads the accumulator directly.
            // This keeps back-to-back frames from mixing.
            acc_next = p1_q;
        end else begin
            ovf_now = sum_ext[AW] ^ sum_ext[AW-1];
            if ((SAT != 0) && ovf_now) begin
                acc_next = sum_ext[AW] ? SUM_MIN : SUM_MAX;
            end
        end
    end

    always_comb begin
        acc_d       = acc_q;
        sticky_d    = sticky_q;
        out_valid_d = 1'b0;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;
        if (clear) begin
            // An in-flight product is discarded and no pulse is produced.
            // The previous result stays visible on out_sum/out_ovf.
            sticky_d = 1'b0;
        end else if (v1_q) begin
            acc_d = acc_next;
            if (last1_q) begin
                out_valid_d = 1'b1;
                out_sum_d   = acc_next;
                out_ovf_d   = sticky_q | ovf_now;
                sticky_d    = 1'b0;
            end else begin
                sticky_d = sticky_q | ovf_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            sticky_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_ovf   = out_ovf_q;
    assign busy      = (cnt_q != '0) || v1_q;

endmodule

// File: tb/tb_bipolar_mac_frame.sv
module tb_bipolar_mac_frame;

  // clock / reset ----------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        clear;
  logic        in_valid;
  logic [11:0] in_data, in_tmpl;

  logic        ov_a, ovf_a, busy_a;
  logic [35:0] sum_a;
  logic        ov_s, ovf_s, busy_s;
  logic [23:0] sum_s;
  logic        ov_w, ovf_w, busy_w;
  logic [23:0] sum_w;
  logic        ov_1, ovf_1, busy_1;
  logic [35:0] sum_1;

  bipolar_mac_frame #(.DW(12), .AW(36), .LEN(4), .SAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_tmpl(in_tmpl), .out_valid(ov_a),
    .out_sum(sum_a), .out_ovf(ovf_a), .busy(busy_a));

  bipolar_mac_frame #(.DW(12), .AW(24), .LEN(4), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_tmpl(in_tmpl), .out_valid(ov_s),
    .out_sum(sum_s), .out_ovf(ovf_s), .busy(busy_s));

  bipolar_mac_frame #(.DW(12), .AW(24), .LEN(4), .SAT(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_tmpl(in_tmpl), .out_valid(ov_w),
    .out_sum(sum_w), .out_ovf(ovf_w), .busy(busy_w));

  bipolar_mac_frame #(.DW(12), .AW(36), .LEN(1), .SAT(1)) dut_1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_data(in_data), .in_tmpl(in_tmpl), .out_valid(ov_1),
    .out_sum(sum_1), .out_ovf(ovf_1), .busy(busy_1));

  // scoreboard: captured output pulses -------------------------------------
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [35:0] a_sum_q[$];
  logic        a_ovf_q[$];
  int          a_cyc_q[$];
  logic [23:0] s_sum_q[$], w_sum_q[$];
  logic        s_ovf_q[$], w_ovf_q[$];
  logic [35:0] one_sum_q[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (ov_a) begin
      a_sum_q.push_back(sum_a); a_ovf_q.push_back(ovf_a); a_cyc_q.push_back(cyc);
    end
    if (ov_s) begin s_sum_q.push_back(sum_s); s_ovf_q.push_back(ovf_s); end
    if (ov_w) begin w_sum_q.push_back(sum_w); w_ovf_q.push_back(ovf_w); end
    if (ov_1) one_sum_q.push_back(sum_1);
  end

  // driver tasks -------------------------------------------------------------
  task automatic drive(input logic v, input int d, input int t, input logic c);
    @(negedge clk);
    in_valid = v;
    in_data  = 12'(d);
    in_tmpl  = 12'(t);
    clear    = c;
  endtask

  task automatic send(input int d, input int t);
    drive(1'b1, d, t, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0);
  endtask

  task automatic flush_queues();
    a_sum_q.delete(); a_ovf_q.delete(); a_cyc_q.delete();
    s_sum_q.delete(); s_ovf_q.delete(); w_sum_q.delete(); w_ovf_q.delete();
    one_sum_q.delete();
  endtask

  // tests ----------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_tmpl = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (ov_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", ov_a); end
    n_checks++; if (sum_a !== 36'd0) begin n_fail++; $display("FAIL reset_sum got=%0d exp=0", sum_a); end
    n_checks++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int    t4;
    longint exp1[4];
    exp1 = '{300, -300, 4194304, -2048};
    flush_queues();
    send(100, 3); send(-100, 3); send(-2048, -2048); send(-2048, 1);
    t4 = cyc;
    idle(4);
    n_checks++; if (a_sum_q.size() !== 1) begin n_fail++; $display("FAIL basic_pulses got=%0d exp=1", a_sum_q.size()); end
    if (a_sum_q.size() == 1) begin
      n_checks++; if ($signed(a_sum_q[0]) !== 64'sd4192256) begin n_fail++; $display("FAIL basic_sum got=%0d exp=4192256", $signed(a_sum_q[0])); end
      n_checks++; if (a_ovf_q[0] !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got=%b exp=0", a_ovf_q[0]); end
      n_checks++; if (a_cyc_q[0] !== t4 + 2) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", a_cyc_q[0], t4 + 2); end
    end
    n_checks++; if (one_sum_q.size() !== 4) begin n_fail++; $display("FAIL len1_pulses got=%0d exp=4", one_sum_q.size()); end
    if (one_sum_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if ($signed(one_sum_q[i]) !== exp1[i]) begin
          n_fail++; $display("FAIL len1_sum[%0d] got=%0d exp=%0d", i, $signed(one_sum_q[i]), exp1[i]);
        end
      end
    end
  endtask

  task automatic test_saturate();
    flush_queues();
    repeat (4) send(-2048, -2048);
    idle(4);
    n_checks++; if (s_sum_q.size() !== 1) begin n_fail++; $display("FAIL sat_pulses got=%0d exp=1", s_sum_q.size()); end
    if (s_sum_q.size() == 1) begin
      n_checks++; if ($signed(s_sum_q[0]) !== 64'sd8388607) begin n_fail++; $display("FAIL sat_sum got=%0d exp=8388607", $signed(s_sum_q[0])); end
      n_checks++; if (s_ovf_q[0] !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got=%b exp=1", s_ovf_q[0]); end
    end
    n_checks++; if (w_sum_q.size() !== 1) begin n_fail++; $display("FAIL wrap_pulses got=%0d exp=1", w_sum_q.size()); end
    if (w_sum_q.size() == 1) begin
      n_checks++; if ($signed(w_sum_q[0]) !== 64'sd0) begin n_fail++; $display("FAIL wrap_sum got=%0d exp=0", $signed(w_sum_q[0])); end
      n_checks++; if (w_ovf_q[0] !== 1'b1) begin n_fail++; $display("FAIL wrap_ovf got=%b exp=1", w_ovf_q[0]); end
    end
    if (a_sum_q.size() == 1) begin
      n_checks++; if ($signed(a_sum_q[0]) !== 64'sd16777216) begin n_fail++; $display("FAIL wide_sum got=%0d exp=16777216", $signed(a_sum_q[0])); end
      n_checks++; if (a_ovf_q[0] !== 1'b0) begin n_fail++; $display("FAIL wide_ovf got=%b exp=0", a_ovf_q[0]); end
    end else begin
      n_checks++; n_fail++; $display("FAIL wide_pulses got=%0d exp=1", a_sum_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int t1;
    flush_queues();
    repeat (4) send(1, 1);
    t1 = cyc;
    repeat (4) send(2, 2);
    idle(4);
    n_checks++; if (a_sum_q.size() !== 2) begin n_fail++; $display("FAIL b2b_pulses got=%0d exp=2", a_sum_q.size()); end
    if (a_sum_q.size() == 2) begin
      n_checks++; if ($signed(a_sum_q[0]) !== 64'sd4) begin n_fail++; $display("FAIL b2b_sum0 got=%0d exp=4", $signed(a_sum_q[0])); end
      n_checks++; if ($signed(a_sum_q[1]) !== 64'sd16) begin n_fail++; $display("FAIL b2b_sum1 got=%0d exp=16", $signed(a_sum_q[1])); end
      n_checks++; if (a_cyc_q[0] !== t1 + 2) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=%0d", a_cyc_q[0], t1 + 2); end
      n_checks++; if (a_cyc_q[1] - a_cyc_q[0] !== 4) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=4", a_cyc_q[1] - a_cyc_q[0]); end
    end
  endtask

  task automatic test_gaps();
    int     dv[4];
    int     tv[4];
    int     g;
    longint golden;
    dv = '{7, -3, 250, -2047};
    tv = '{-9, 11, -4, -2047};
    golden = 0;
    for (int i = 0; i < 4; i++) golden += longint'(dv[i]) * longint'(tv[i]);
    flush_queues();
    @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL gaps_idle_busy got=%b exp=0", busy_a); end
    for (int i = 0; i < 4; i++) begin
      send(dv[i], tv[i]);
      if (i < 3) begin
        g = $urandom_range(0, 5);
        for (int k = 0; k < g; k++) begin
          drive(1'b0, 0, 0, 1'b0);
          n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL gaps_busy[%0d] got=%b exp=1", i, busy_a); end
        end
      end
    end
    drive(1'b0, 0, 0, 1'b0);
    n_checks++; if (busy_a !== 1'b1 || ov_a !== 1'b0) begin n_fail++; $display("FAIL gaps_tail busy=%b valid=%b exp busy=1 valid=0", busy_a, ov_a); end
    idle(3);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL gaps_done_busy got=%b exp=0", busy_a); end
    n_checks++; if (a_sum_q.size() !== 1) begin n_fail++; $display("FAIL gaps_pulses got=%0d exp=1", a_sum_q.size()); end
    if (a_sum_q.size() == 1) begin
      n_checks++; if ($signed(a_sum_q[0]) !== golden || golden !== 64'sd4189113) begin n_fail++; $display("FAIL gaps_sum got=%0d exp=%0d", $signed(a_sum_q[0]), golden); end
    end
  endtask

  task automatic test_clear();
    flush_queues();
    send(9, 9); send(9, 9);
    drive(1'b1, 100, 100, 1'b1);   // clear and a sample in the same cycle
    drive(1'b0, 0, 0, 1'b0);
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL clear_busy got=%b exp=0", busy_a); end
    n_checks++; if ($signed(sum_a) !== 64'sd4189113) begin n_fail++; $display("FAIL clear_hold_sum got=%0d exp=4189113", $signed(sum_a)); end
    repeat (4) send(1, 5);
    idle(4);
    n_checks++; if (a_sum_q.size() !== 1) begin n_fail++; $display("FAIL clear_pulses got=%0d exp=1", a_sum_q.size()); end
    if (a_sum_q.size() == 1) begin
      n_checks++; if ($signed(a_sum_q[0]) !== 64'sd20) begin n_fail++; $display("FAIL clear_sum got=%0d exp=20", $signed(a_sum_q[0])); end
      n_checks++; if (a_ovf_q[0] !== 1'b0) begin n_fail++; $display("FAIL clear_ovf got=%b exp=0", a_ovf_q[0]); end
    end
  endtask

  task automatic test_async_reset();
    flush_queues();
    send(3, 3); send(4, 4);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (sum_a !== 36'd0) begin n_fail++; $display("FAIL areset_sum got=%0d exp=0", sum_a); end
    n_checks++; if (ov_a !== 1'b0 || ovf_a !== 1'b0) begin n_fail++; $display("FAIL areset_flags valid=%b ovf=%b exp=0", ov_a, ovf_a); end
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b exp=0", busy_a); end
    @(negedge clk);
    rst_n = 1'b1;
    send(2, 1); send(3, 1); send(4, 1); send(5, 1);
    idle(4);
    n_checks++; if (a_sum_q.size() !== 1) begin n_fail++; $display("FAIL areset_pulses got=%0d exp=1", a_sum_q.size()); end
    if (a_sum_q.size() == 1) begin
      n_checks++; if ($signed(a_sum_q[0]) !== 64'sd14) begin n_fail++; $display("FAIL areset_after_sum got=%0d exp=14", $signed(a_sum_q[0])); end
    end
  endtask

  // sequence and final report -------------------------------------------------
  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_gaps();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
